// File: rtl/crtc_bus_sequencer.sv
// crtc_bus_sequencer
//   Sole bus master for an MC6845 CRTC. After reset, or when INIT_REQ
//   pulses, it writes the 16-entry INIT_TABLE to R0..R15. Once that load
//   has finished it serves host register writes over a req/ack handshake.
//   The most recently written address-register value is cached, so a
//   repeat write to the same register skips the address phase.
//
//   Ports
//     CLK, RSTn              clock, async active-low reset
//     INIT_REQ               pulse: restart the table load
//     HOST_REQ/ADDR/DATA     host write request (held until HOST_ACK)
//     HOST_ACK, HOST_ERR     completion pulse, error flag (HOST_ADDR > 17)
//     INIT_DONE              table load complete
//     E, CSn, RS, RW, D_OUT  CRTC write bus
//
//   Optional build macro SHADOW_READBACK_EN adds SHADOW_ADDR/SHADOW_DATA,
//   a readable copy of R0..R15 (the CRTC registers are write-only).
//
//   state    | meaning
//   IDLE     | bus released; arbitrate table load vs. host request
//   A_SETUP  | address register selected, E low
//   A_STROBE | address phase, E high for E_WIDTH cycles
//   A_HOLD   | E low, address held across the falling edge
//   D_SETUP  | data register selected, E low
//   D_STROBE | data phase, E high for E_WIDTH cycles
//   D_HOLD   | E low, data held; host ACK / table index advance
module crtc_bus_sequencer #(
  parameter int unsigned  E_WIDTH    = 2,
  parameter logic [127:0] INIT_TABLE = 128'h000000000C0B0D0219190619_0F525061
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       INIT_REQ,
  input  logic       HOST_REQ,
  input  logic [4:0] HOST_ADDR,
  input  logic [7:0] HOST_DATA,
  output logic       HOST_ACK,
  output logic       HOST_ERR,
  output logic       INIT_DONE,
  output logic       E,
  output logic       CSn,
  output logic       RS,
  output logic       RW,
  output logic [7:0] D_OUT
`ifdef SHADOW_READBACK_EN
  ,
  input  logic [3:0] SHADOW_ADDR,
  output logic [7:0] SHADOW_DATA
`endif
);

  typedef enum logic [2:0] {
    IDLE, A_SETUP, A_STROBE, A_HOLD, D_SETUP, D_STROBE, D_HOLD
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [4:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic       is_init_q, is_init_d;
  logic [3:0] idx_q, idx_d;
  logic       load_q, load_d;
  logic       restart_q, restart_d;
  logic       done_q, done_d;
  logic [4:0] cache_q, cache_d;
  logic       cache_vld_q, cache_vld_d;
  logic       ack_q, ack_d, err_q, err_d;
  logic       e_q, e_d, csn_q, csn_d, rs_q, rs_d, rw_q, rw_d;
  logic [7:0] dout_q, dout_d;

  logic       start_init, start_host, restart_now;
  logic [3:0] load_idx;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    data_d      = data_q;
    is_init_d   = is_init_q;
    idx_d       = idx_q;
    load_d      = load_q | INIT_REQ;
    restart_d   = restart_q | INIT_REQ;
    done_d      = INIT_REQ ? 1'b0 : done_q;
    cache_d     = cache_q;
    cache_vld_d = cache_vld_q & ~INIT_REQ;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    start_init  = 1'b0;
    start_host  = 1'b0;
    restart_now = restart_q | INIT_REQ;
    load_idx    = restart_now ? 4'd0 : idx_q;

    case (state_q)
      IDLE: begin
        if (load_q || INIT_REQ) begin
          start_init = 1'b1;
        end else if (done_q && HOST_REQ && !ack_q) begin
          // ack_q guard: a bad-address ACK is issued from IDLE while the
          // host still holds HOST_REQ; do not capture it a second time.
          if (HOST_ADDR > 5'd17) begin
            ack_d = 1'b1;
            err_d = 1'b1;
          end else begin
            start_host = 1'b1;
          end
        end
      end
      A_SETUP: begin
        state_d = A_STROBE;
        cnt_d   = 4'(E_WIDTH - 1);
      end
      A_STROBE: begin
        if (cnt_q == 4'd0) state_d = A_HOLD;
        else               cnt_d   = cnt_q - 4'd1;
      end
      A_HOLD: begin
        state_d     = D_SETUP;
        cache_d     = addr_q;
        cache_vld_d = ~INIT_REQ;
      end
      D_SETUP: begin
        state_d = D_STROBE;
        cnt_d   = 4'(E_WIDTH - 1);
      end
      D_STROBE: begin
        if (cnt_q == 4'd0) state_d = D_HOLD;
        else               cnt_d   = cnt_q - 4'd1;
      end
      D_HOLD: begin
        state_d = IDLE;
        if (is_init_q) begin
          // Table entries chain directly without an IDLE gap.
          if (!restart_now && idx_q == 4'd15) begin
            load_d = 1'b0;
            done_d = 1'b1;
            idx_d  = 4'd0;
          end else begin
            load_idx   = restart_now ? 4'd0 : idx_q + 4'd1;
            start_init = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (start_init) begin
      addr_d    = {1'b0, load_idx};
      data_d    = INIT_TABLE[{load_idx, 3'b000} +: 8];
      is_init_d = 1'b1;
      idx_d     = load_idx;
      restart_d = 1'b0;
      load_d    = 1'b1;
    end
    if (start_host) begin
      addr_d    = HOST_ADDR;
      data_d    = HOST_DATA;
      is_init_d = 1'b0;
    end
    if (start_init || start_host) begin
      state_d = (cache_vld_q && !INIT_REQ && cache_q == addr_d) ? D_SETUP : A_SETUP;
    end

    if (state_d == D_HOLD && !is_init_d) ack_d = 1'b1;

    // Bus outputs are registered from the next state so E is glitch-free.
    e_d    = (state_d == A_STROBE) || (state_d == D_STROBE);
    csn_d  = (state_d == IDLE);
    rw_d   = (state_d == IDLE);
    rs_d   = (state_d == D_SETUP) || (state_d == D_STROBE) || (state_d == D_HOLD);
    dout_d = 8'h00;
    if (state_d == A_SETUP || state_d == A_STROBE || state_d == A_HOLD)
      dout_d = {3'b000, addr_d};
    else if (rs_d)
      dout_d = data_d;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= 5'd0;
      data_q      <= 8'h00;
      is_init_q   <= 1'b0;
      idx_q       <= 4'd0;
      load_q      <= 1'b1;
      restart_q   <= 1'b0;
      done_q      <= 1'b0;
      cache_q     <= 5'd0;
      cache_vld_q <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      e_q         <= 1'b0;
      csn_q       <= 1'b1;
      rs_q        <= 1'b0;
      rw_q        <= 1'b1;
      dout_q      <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      is_init_q   <= is_init_d;
      idx_q       <= idx_d;
      load_q      <= load_d;
      restart_q   <= restart_d;
      done_q      <= done_d;
      cache_q     <= cache_d;
      cache_vld_q <= cache_vld_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      e_q         <= e_d;
      csn_q       <= csn_d;
      rs_q        <= rs_d;
      rw_q        <= rw_d;
      dout_q      <= dout_d;
    end
  end

  assign HOST_ACK  = ack_q;
  assign HOST_ERR  = err_q;
  assign INIT_DONE = done_q;
  assign E         = e_q;
  assign CSn       = csn_q;
  assign RS        = rs_q;
  assign RW        = rw_q;
  assign D_OUT     = dout_q;

`ifdef SHADOW_READBACK_EN
  logic [7:0] shadow_q [16];

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < 16; i++) shadow_q[i] <= 8'h00;
    end else if (state_q == D_HOLD && !addr_q[4]) begin
      shadow_q[addr_q[3:0]] <= data_q;
    end
  end

  assign SHADOW_DATA = shadow_q[SHADOW_ADDR];
`endif

endmodule

// File: tb/tb_crtc_bus_sequencer.sv
module tb_crtc_bus_sequencer;
  localparam int EW = 2;

  logic       CLK = 1'b0;
  logic       RSTn;
  logic       INIT_REQ;
  logic       HOST_REQ;
  logic [4:0] HOST_ADDR;
  logic [7:0] HOST_DATA;
  logic       HOST_ACK, HOST_ERR, INIT_DONE, E, CSn, RS, RW;
  logic [7:0] D_OUT;
`ifdef SHADOW_READBACK_EN
  logic [3:0] SHADOW_ADDR;
  logic [7:0] SHADOW_DATA;
`endif

  crtc_bus_sequencer #(.E_WIDTH(EW)) dut (
    .CLK(CLK), .RSTn(RSTn), .INIT_REQ(INIT_REQ),
    .HOST_REQ(HOST_REQ), .HOST_ADDR(HOST_ADDR), .HOST_DATA(HOST_DATA),
    .HOST_ACK(HOST_ACK), .HOST_ERR(HOST_ERR), .INIT_DONE(INIT_DONE),
    .E(E), .CSn(CSn), .RS(RS), .RW(RW), .D_OUT(D_OUT)
`ifdef SHADOW_READBACK_EN
    , .SHADOW_ADDR(SHADOW_ADDR), .SHADOW_DATA(SHADOW_DATA)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct { logic rs; logic [7:0] d; } bus_t;
  typedef struct { logic [4:0] a; logic [7:0] d; bit err; int lat; } vec_t;

  bus_t        sbq[$];
  logic [127:0] tbl;
  logic [4:0]  mc;
  bit          mc_vld;
  bit          mon_en;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input bit ok, input string nm, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard model: the address phase is expected only on a cache miss.
  task automatic push_write(input logic [4:0] a, input logic [7:0] d);
    bus_t b;
    if (!mc_vld || mc != a) begin
      b.rs = 1'b0; b.d = {3'b000, a};
      sbq.push_back(b);
    end
    b.rs = 1'b1; b.d = d;
    sbq.push_back(b);
    mc = a; mc_vld = 1'b1;
  endtask

  task automatic push_load();
    mc_vld = 1'b0;
    for (int i = 0; i < 16; i++) push_write(5'(i), tbl[8*i +: 8]);
  endtask

  // Bus monitor: every falling edge of E is one CRTC write.
  initial begin
    logic prev_e;
    int   e_run;
    bus_t ex;
    prev_e = 1'b0;
    e_run  = 0;
    forever begin
      @(negedge CLK);
      if (!mon_en) e_run = 0;
      else if (E) e_run++;
      else if (prev_e) begin
        chk(e_run == EW, "e_width", e_run, EW);
        chk(!CSn && !RW, "cs_rw_at_fall", {CSn, RW}, 0);
        chk(sbq.size() != 0, "unexpected_write", {RS, D_OUT}, 0);
        if (sbq.size() != 0) begin
          ex = sbq.pop_front();
          chk({RS, D_OUT} == {ex.rs, ex.d}, "bus_write", {RS, D_OUT}, {ex.rs, ex.d});
        end
        e_run = 0;
      end
      prev_e = E;
    end
  end

  task automatic wait_done(input string nm);
    int n = 0;
    bit got = 0;
    while (!got && n < 400) begin
      @(posedge CLK); #1; n++;
      if (INIT_DONE) got = 1;
    end
    chk(got && n == 129, nm, n, 129);
  endtask

  // Host write, driven while the DUT is idle; latency counted in cycles
  // after the capture cycle up to and including the ACK cycle.
  task automatic host_wr(input logic [4:0] a, input logic [7:0] d,
                         input bit exp_err, input int exp_lat);
    int n = 0, cs = 0;
    bit got = 0;
    @(posedge CLK); #1;
    if (!exp_err) push_write(a, d);
    HOST_REQ = 1'b1; HOST_ADDR = a; HOST_DATA = d;
    while (!got && n < 50) begin
      @(posedge CLK); #1; n++;
      if (!CSn) cs++;
      if (HOST_ACK) got = 1;
    end
    chk(got, "host_ack_seen", n, exp_lat);
    chk(n == exp_lat, "host_latency", n, exp_lat);
    chk(HOST_ERR == exp_err, "host_err", HOST_ERR, exp_err);
    chk(cs == (exp_err ? 0 : exp_lat), "csn_low_cycles", cs, exp_err ? 0 : exp_lat);
    HOST_REQ = 1'b0;
  endtask

  vec_t vecs[9];

  initial begin
    int  n;
    bit  got, bad_ack;

    tbl = 128'h000000000C0B0D0219190619_0F525061;
    vecs[0] = '{5'h0E, 8'h3F, 1'b0, 8};
    vecs[1] = '{5'h0E, 8'h12, 1'b0, 4};
    vecs[2] = '{5'h1F, 8'h00, 1'b1, 1};
    vecs[3] = '{5'h0E, 8'h55, 1'b0, 4};
    vecs[4] = '{5'h11, 8'hA5, 1'b0, 8};
    vecs[5] = '{5'h12, 8'hC3, 1'b1, 1};
    vecs[6] = '{5'h11, 8'h5A, 1'b0, 4};
    vecs[7] = '{5'h00, 8'h77, 1'b0, 8};
    vecs[8] = '{5'h0A, 8'h20, 1'b0, 8};

    RSTn = 1'b0; INIT_REQ = 1'b0; HOST_REQ = 1'b0; HOST_ADDR = '0; HOST_DATA = '0;
    mc = '0; mc_vld = 1'b0; mon_en = 1'b1;
`ifdef SHADOW_READBACK_EN
    SHADOW_ADDR = 4'd1;
`endif
    repeat (3) @(posedge CLK);
    #1;
    chk(E == 1'b0,       "rst_E", E, 0);
    chk(CSn == 1'b1,     "rst_CSn", CSn, 1);
    chk(RS == 1'b0,      "rst_RS", RS, 0);
    chk(RW == 1'b1,      "rst_RW", RW, 1);
    chk(D_OUT == 8'h00,  "rst_D_OUT", D_OUT, 0);
    chk(HOST_ACK == 1'b0 && HOST_ERR == 1'b0, "rst_ack_err", {HOST_ACK, HOST_ERR}, 0);
    chk(INIT_DONE == 1'b0, "rst_INIT_DONE", INIT_DONE, 0);

    push_load();
    @(negedge CLK);
    RSTn = 1'b1;
    wait_done("init_done_latency");

    for (int i = 0; i < 9; i++)
      host_wr(vecs[i].a, vecs[i].d, vecs[i].err, vecs[i].lat);

    // INIT_REQ during the data strobe of a host write.
    @(posedge CLK); #1;
    push_write(5'h03, 8'h44);
    HOST_REQ = 1'b1; HOST_ADDR = 5'h03; HOST_DATA = 8'h44;
    got = 0; n = 0;
    while (!got && n < 30) begin
      @(posedge CLK); #1; n++;
      if (E && RS && !CSn) got = 1;
    end
    chk(got, "reach_d_strobe", n, 0);
    INIT_REQ = 1'b1;
    push_load();
    @(posedge CLK); #1;
    INIT_REQ = 1'b0;
    got = HOST_ACK; n = 0;
    while (!got && n < 30) begin
      @(posedge CLK); #1; n++;
      if (HOST_ACK) got = 1;
    end
    chk(got, "ack_after_init_req", n, 0);
    chk(INIT_DONE == 1'b0, "init_done_dropped", INIT_DONE, 0);
    HOST_REQ = 1'b1; HOST_ADDR = 5'h05; HOST_DATA = 8'h99;
    push_write(5'h05, 8'h99);
    got = 0; bad_ack = 0; n = 0;
    while (!got && n < 400) begin
      @(posedge CLK); #1; n++;
      if (HOST_ACK) bad_ack = 1;
      if (INIT_DONE) got = 1;
    end
    chk(got, "reload_done", n, 0);
    chk(!bad_ack, "host_stalled_during_load", bad_ack, 0);
    got = 0; n = 0;
    while (!got && n < 50) begin
      @(posedge CLK); #1; n++;
      if (HOST_ACK) got = 1;
    end
    chk(got && n == 8, "pending_host_latency", n, 8);
    HOST_REQ = 1'b0;

    // Reset asserted during an address strobe.
    @(posedge CLK); #1;
    HOST_REQ = 1'b1; HOST_ADDR = 5'h09; HOST_DATA = 8'h21;
    got = 0; n = 0;
    while (!got && n < 30) begin
      @(posedge CLK); #1; n++;
      if (E && !RS && !CSn) got = 1;
    end
    chk(got, "reach_a_strobe", n, 0);
    chk(sbq.size() == 0, "queue_empty_before_reset", sbq.size(), 0);
    mon_en = 1'b0;
    RSTn = 1'b0;
    #1;
    chk(E == 1'b0,      "midrst_E", E, 0);
    chk(CSn == 1'b1,    "midrst_CSn", CSn, 1);
    chk(RW == 1'b1 && RS == 1'b0 && D_OUT == 8'h00, "midrst_bus", {RW, RS, D_OUT}, 9'h100);
    chk(INIT_DONE == 1'b0, "midrst_INIT_DONE", INIT_DONE, 0);
    HOST_REQ = 1'b0;
    sbq.delete();
    repeat (2) @(posedge CLK);
    #1;
    mon_en = 1'b1;
    push_load();
    @(negedge CLK);
    RSTn = 1'b1;
    wait_done("reinit_done_latency");

`ifdef SHADOW_READBACK_EN
    SHADOW_ADDR = 4'd1;
    #1;
    chk(SHADOW_DATA == 8'h50, "shadow_r1", SHADOW_DATA, 8'h50);
    SHADOW_ADDR = 4'd12;
    #1;
    chk(SHADOW_DATA == 8'h00, "shadow_r12", SHADOW_DATA, 8'h00);
`endif

    repeat (4) @(posedge CLK);
    #1;
    chk(sbq.size() == 0, "queue_drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/crtc_bus_sequencer.md
Name: crtc_bus_sequencer

Overview:
- Bus master for the MC6845 processor interface: generates the E/CSn/RS/RW/D write cycles that program the CRTC registers.
- After reset, or on request, it writes a 16-entry register table (R0–R15) to the CRTC.
- After that it serves host register-write requests over a req/ack handshake.
- It sits between the system host logic and the CRTC, and is the only driver of the CRTC bus.

Parameters:
- E_WIDTH, 2, number of CLK cycles E is held high per bus phase (1..15).
- INIT_TABLE, 128'h000000000C0B0D0219190619_0F525061, init values; entry i (for R_i) is in bits [8i+7:8i]. Default is the MDA text mode.

Ports:
- CLK  in  1  system clock, rising-edge active.
- RSTn  in  1  asynchronous active-low reset.
- INIT_REQ  in  1  one-cycle pulse that restarts the table load.
- HOST_REQ  in  1  host write request; held until HOST_ACK.
- HOST_ADDR  in  5  target CRTC register number.
- HOST_DATA  in  8  value to write.
- HOST_ACK  out  1  one-cycle pulse when the request completes.
- HOST_ERR  out  1  one-cycle pulse, coincident with HOST_ACK, when HOST_ADDR > 17.
- INIT_DONE  out  1  high once the table load has completed.
- E  out  1  CRTC enable strobe; the CRTC latches on its falling edge.
- CSn  out  1  CRTC chip select, active low.
- RS  out  1  0 = address register, 1 = data register.
- RW  out  1  0 = write.
- D_OUT  out  8  CRTC data bus, write direction only.

Behaviour:
- Reset (asynchronous, RSTn low) forces these values:
  - E=0, CSn=1, RS=0, RW=1, D_OUT=0.
  - HOST_ACK=0, HOST_ERR=0, INIT_DONE=0.
  - State = IDLE, init index = 0.
  - Address cache invalid.
  - The table load is armed and starts on the first clock after RSTn rises.
- States: IDLE, A_SETUP, A_STROBE, A_HOLD, D_SETUP, D_STROBE, D_HOLD.
- SETUP (1 cycle): CSn=0, RW=0, RS=0 for A / 1 for D, D_OUT valid (A: {3'b0,addr}; D: data), E=0.
- STROBE (E_WIDTH cycles): same as SETUP, with E=1.
- HOLD (1 cycle): E=0, with CSn, RS, RW and D_OUT unchanged. This keeps data stable across E's falling edge.
- Returning to IDLE restores CSn=1, RW=1, RS=0, D_OUT=0.
- Address cache:
  - Holds the last register number written to the CRTC address register.
  - If the target equals the cached value, the A phases are skipped and IDLE goes directly to D_SETUP.
  - The cache is invalidated by reset and by INIT_REQ.
- Cycle counts:
  - Full write: 2*(E_WIDTH+2) cycles, i.e. 8 at the default.
  - Data-only write: E_WIDTH+2 cycles.
- Arbitration, evaluated in IDLE only:
  - The pending table load has priority over a host request.
  - During the load, HOST_REQ is stalled (no ACK).
  - After INIT_DONE, an IDLE cycle with HOST_REQ=1 captures HOST_ADDR/HOST_DATA and starts a cycle.
  - HOST_ACK pulses in the D_HOLD cycle.
- Table load:
  - Entries 0..15 are written in order, each to register i.
  - The index increments at each D_HOLD.
  - INIT_DONE rises in the cycle after the D_HOLD of entry 15.
  - The first entry always includes an A phase, because the cache is invalid. Later entries also use A phases, since the index changes.
- Bad address (HOST_ADDR > 17): no bus cycle. HOST_ACK and HOST_ERR pulse together one cycle after capture; the cache is unchanged.
- INIT_REQ:
  - Sets an internal pending flag, clears INIT_DONE and invalidates the cache.
  - If it arrives mid-cycle, the current bus cycle runs to completion, including HOST_ACK if it was a host cycle.
  - The load then restarts at index 0.
  - INIT_REQ asserted during an ongoing load restarts from index 0 after the current cycle.
- HOST_REQ must be held until ACK; HOST_ADDR/HOST_DATA are sampled only at capture.
- Two back-to-back requests to the same register: the second request is data-only.
- RSTn asserted mid-cycle: outputs return immediately to their reset values. The CRTC sees no E falling edge unless E was already high.

Optional Feature:
- SHADOW_READBACK_EN: when defined, adds these ports:
  - SHADOW_ADDR  in  4
  - SHADOW_DATA  out  8
- SHADOW_DATA is the combinational readout of a 16x8 shadow of R0–R15.
- The shadow is updated at each D_HOLD whose target is ≤15.
- Shadow reset value: all zero.
- Without the macro, there is no shadow storage and no extra ports. This compensates for the CRTC registers being write-only.

Test Plan:
- Release reset, E_WIDTH=2 -> 16 register writes of 8 cycles each (RS=0 then RS=1), D_OUT data sequence 61,50,52,0F,…,00; INIT_DONE high at cycle 129.
- After INIT_DONE: HOST_REQ addr=0E data=3F -> A phase with D_OUT=0E, D phase with D_OUT=3F, E high 2 cycles per phase, HOST_ACK at cycle 8.
- Immediately repeat HOST_REQ addr=0E data=12 -> no A phase, D_OUT=12, HOST_ACK after 4 cycles.
- HOST_REQ addr=1F -> no CSn activity, HOST_ACK and HOST_ERR pulse together one cycle after capture.
- INIT_REQ during the D_STROBE of a host write -> host write finishes with ACK, INIT_DONE drops, the load restarts at R0 with an A phase, and a pending HOST_REQ waits until the new INIT_DONE.
- RSTn low during A_STROBE -> E=0 and CSn=1 immediately; after release, the load restarts at R0. With SHADOW_READBACK_EN, SHADOW_ADDR=1 reads 50 after the load.
